// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared constants and types for the MIMA fetch program counter
//               and its return-address stack.
//               PC_SEL_* is the one-hot priority select that drives the
//               next-cur mux in pc_ras.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int ILEN_BYTES_DEF = 4;

    typedef enum logic [3:0] {
        PC_SEL_HOLD = 4'b0001,
        PC_SEL_RET  = 4'b0010,
        PC_SEL_JMP  = 4'b0100,
        PC_SEL_SEQ  = 4'b1000
    } pc_sel_e;

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Circular return-address stack.
//               A push onto a full stack overwrites the oldest entry and
//               pulses ovf. A pop from an empty stack pulses unf and leaves
//               the stack as it is. push and pop are never both requested
//               in the same cycle (the caller gives ret priority over jmp).
// Ports       : clk, rst        - clock and synchronous active-high reset
//               push, push_data - write a new top entry
//               pop             - discard the top entry
//               top             - top entry, 0 when empty
//               cnt             - number of valid entries
//               empty, full     - cnt == 0 / cnt == RAS_DEPTH
//               ovf, unf        - one-cycle pulses after the causing edge
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic                               pop,
    input  logic [XLEN-1:0]                    push_data,
    output logic [XLEN-1:0]                    top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     cnt,
    output logic                               empty,
    output logic                               full,
    output logic                               ovf,
    output logic                               unf
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   tp_q, tp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            wr_en;
    logic [PW-1:0]   tp_inc;
    logic [PW-1:0]   tp_dec;

    // Pointer arithmetic wraps explicitly so non-power-of-two depths work.
    assign tp_inc = (tp_q == PW'(RAS_DEPTH - 1)) ? '0 : tp_q + PW'(1);
    assign tp_dec = (tp_q == '0) ? PW'(RAS_DEPTH - 1) : tp_q - PW'(1);

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(RAS_DEPTH));
    assign cnt   = cnt_q;
    assign top   = empty ? '0 : mem_q[tp_q];
    assign ovf   = ovf_q;
    assign unf   = unf_q;

    always_comb begin
        tp_d  = tp_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        wr_en = 1'b0;
        if (push) begin
            // When full, advancing the pointer lands on the oldest entry,
            // which is what gets overwritten.
            tp_d  = tp_inc;
            wr_en = 1'b1;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                tp_d  = tp_dec;
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage needs no reset: entries are only visible below cnt.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[tp_d] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : pc_ras
// Description : Fetch program counter with integrated return-address stack.
//               Per-cycle priority: rst > stall > ret > jmp > sequential.
//               cur is registered; there is no combinational input->cur path.
//               Optional macro PC_MISALIGN_EN adds the mis port: redirect
//               targets have their low bits cleared and mis pulses when any
//               were set (ILEN_BYTES must be a power of two).
// Ports       : clk, rst, stall           - clock, sync reset, hold
//               jmp, rel, nxt, call, ret  - redirect / call / return controls
//               cur                       - current fetch address
//               ras_top, ras_cnt, ras_empty, ras_full - stack status
//               ras_ovf, ras_unf          - stack overflow/underflow pulses
//               mis                       - misaligned redirect pulse (opt.)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ras
    import pc_pkg::*;
#(
    parameter int               XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_VEC  = '0,
    parameter int               ILEN_BYTES = ILEN_BYTES_DEF,
    parameter int               RAS_DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               stall,
    input  logic                               jmp,
    input  logic                               rel,
    input  logic [XLEN-1:0]                    nxt,
    input  logic                               call,
    input  logic                               ret,
    output logic [XLEN-1:0]                    cur,
    output logic [XLEN-1:0]                    ras_top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_cnt,
    output logic                               ras_empty,
    output logic                               ras_full,
    output logic                               ras_ovf,
    output logic                               ras_unf
`ifdef PC_MISALIGN_EN
    ,
    output logic                               mis
`endif
);

    logic [XLEN-1:0] cur_q, cur_d;
    logic [XLEN-1:0] seq_addr;
    logic [XLEN-1:0] jmp_tgt;
    logic [XLEN-1:0] raw_next;
    logic            redirect;
    logic            push;
    logic            pop;
    pc_sel_e         sel;

    assign seq_addr = cur_q + XLEN'(ILEN_BYTES);
    assign jmp_tgt  = rel ? (cur_q + nxt) : nxt;

    always_comb begin
        sel = PC_SEL_SEQ;
        if (stall) begin
            sel = PC_SEL_HOLD;
        end else if (ret) begin
            sel = PC_SEL_RET;
        end else if (jmp) begin
            sel = PC_SEL_JMP;
        end
    end

    // A ret on an empty stack is a plain sequential step, not a redirect.
    always_comb begin
        raw_next = seq_addr;
        redirect = 1'b0;
        unique case (sel)
            PC_SEL_HOLD: raw_next = cur_q;
            PC_SEL_RET: begin
                raw_next = ras_empty ? seq_addr : ras_top;
                redirect = !ras_empty;
            end
            PC_SEL_JMP: begin
                raw_next = jmp_tgt;
                redirect = 1'b1;
            end
            default:     raw_next = seq_addr;
        endcase
    end

    assign push = (sel == PC_SEL_JMP) && call;
    assign pop  = (sel == PC_SEL_RET);

`ifdef PC_MISALIGN_EN
    localparam logic [XLEN-1:0] C_LOW_MASK = XLEN'(ILEN_BYTES - 1);

    logic mis_q, mis_d;

    always_comb begin
        cur_d = raw_next;
        mis_d = 1'b0;
        if (redirect) begin
            cur_d = raw_next & ~C_LOW_MASK;
            mis_d = |(raw_next & C_LOW_MASK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign mis = mis_q;
`else
    always_comb begin
        cur_d = raw_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= RESET_VEC;
        end else begin
            cur_q <= cur_d;
        end
    end

    assign cur = cur_q;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (seq_addr),
        .top       (ras_top),
        .cnt       (ras_cnt),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

endmodule
`default_nettype wire

// File: tb/tb_pc_ras.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_ras
// Description : Self-checking bench for pc_ras (defaults: XLEN 32,
//               RESET_VEC 0, ILEN_BYTES 4, RAS_DEPTH 4). Directed scenarios
//               followed by random traffic, all compared against a queue-based
//               reference model of the program counter and return stack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_ras;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, stall, jmp, rel, call, ret;
    logic [31:0] nxt;
    logic [31:0] cur, ras_top;
    logic [2:0]  ras_cnt;
    logic        ras_empty, ras_full, ras_ovf, ras_unf;
`ifdef PC_MISALIGN_EN
    logic        mis;
`endif

    pc_ras #(
        .XLEN       (32),
        .RESET_VEC  (32'h0),
        .ILEN_BYTES (4),
        .RAS_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .jmp       (jmp),
        .rel       (rel),
        .nxt       (nxt),
        .call      (call),
        .ret       (ret),
        .cur       (cur),
        .ras_top   (ras_top),
        .ras_cnt   (ras_cnt),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
`ifdef PC_MISALIGN_EN
        ,
        .mis       (mis)
`endif
    );

    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_cur;
    logic [31:0] m_ras[$];
    logic        m_ovf, m_unf, m_mis;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] redir(input logic [31:0] t);
`ifdef PC_MISALIGN_EN
        m_mis = (t[1:0] != 2'b00);
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    task automatic model_step(input logic r, input logic s, input logic j, input logic rl,
                              input logic [31:0] n, input logic c, input logic rt);
        logic [31:0] t;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_mis = 1'b0;
        if (r) begin
            m_cur = 32'h0;
            m_ras.delete();
        end else if (s) begin
            // hold
        end else if (rt) begin
            if (m_ras.size() > 0) begin
                t = m_ras.pop_back();
                m_cur = redir(t);
            end else begin
                m_cur = m_cur + 32'd4;
                m_unf = 1'b1;
            end
        end else if (j) begin
            t = rl ? m_cur + n : n;
            if (c) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(m_cur + 32'd4);
            end
            m_cur = redir(t);
        end else begin
            m_cur = m_cur + 32'd4;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_top;
        exp_top = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
        chk({tag, ".cur"},   cur, m_cur);
        chk({tag, ".top"},   ras_top, exp_top);
        chk({tag, ".cnt"},   {29'd0, ras_cnt}, m_ras.size());
        chk({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
        chk({tag, ".full"},  {31'd0, ras_full}, {31'd0, m_ras.size() == DEPTH});
        chk({tag, ".ovf"},   {31'd0, ras_ovf}, {31'd0, m_ovf});
        chk({tag, ".unf"},   {31'd0, ras_unf}, {31'd0, m_unf});
`ifdef PC_MISALIGN_EN
        chk({tag, ".mis"},   {31'd0, mis}, {31'd0, m_mis});
`endif
    endtask

    // Drive one cycle, advance the model, sample 1 time unit after the edge.
    task automatic cyc(input string tag, input logic r, input logic s, input logic j,
                       input logic rl, input logic [31:0] n, input logic c, input logic rt);
        rst = r; stall = s; jmp = j; rel = rl; nxt = n; call = c; ret = rt;
        @(posedge clk);
        model_step(r, s, j, rl, n, c, rt);
        #1;
        check_all(tag);
    endtask

    task automatic free(input string tag);
        cyc(tag, 0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; jmp = 1'b0; rel = 1'b0; nxt = '0; call = 1'b0; ret = 1'b0;
        m_cur = 32'h0; m_ovf = 1'b0; m_unf = 1'b0; m_mis = 1'b0;

        // Reset and free run
        cyc("reset", 1, 0, 0, 0, 32'h0, 0, 0);
        chk("reset.cur_lit", cur, 32'h0);
        for (int i = 0; i < 6; i++) free("seq");
        chk("seq.cur_lit", cur, 32'h18);

        // Absolute jump
        cyc("jabs", 0, 0, 1, 0, 32'h1000, 0, 0);
        chk("jabs.cur_lit", cur, 32'h1000);
        free("jabs.step");
        chk("jabs.step_lit", cur, 32'h1004);
        free("s"); free("s"); free("s");

        // Relative negative jump
        cyc("jrel", 0, 0, 1, 1, 32'hffffffec, 0, 0);
        chk("jrel.cur_lit", cur, 32'h0ffc);

        // Wrap at 2^32
        cyc("jtop", 0, 0, 1, 0, 32'hfffffffc, 0, 0);
        free("wrap");
        chk("wrap.cur_lit", cur, 32'h0);

        // Call / return
        cyc("j100", 0, 0, 1, 0, 32'h100, 0, 0);
        cyc("call", 0, 0, 1, 0, 32'h2000, 1, 0);
        chk("call.top_lit", ras_top, 32'h104);
        free("s");
        cyc("ret", 0, 0, 0, 0, 32'h0, 0, 1);
        chk("ret.cur_lit", cur, 32'h104);

        // Five nested calls, overflow on the fifth
        cyc("j10", 0, 0, 1, 0, 32'h10, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc("call5", 0, 0, 1, 0, 32'((i + 1) * 16), 1, 0);
            chk("call5.ovf_lit", {31'd0, ras_ovf}, {31'd0, i == 5});
        end
        cyc("r1", 0, 0, 0, 0, 32'h0, 0, 1); chk("r1.lit", cur, 32'h54);
        cyc("r2", 0, 0, 0, 0, 32'h0, 0, 1); chk("r2.lit", cur, 32'h44);
        cyc("r3", 0, 0, 0, 0, 32'h0, 0, 1); chk("r3.lit", cur, 32'h34);
        cyc("r4", 0, 0, 0, 0, 32'h0, 0, 1); chk("r4.lit", cur, 32'h24);
        cyc("r5", 0, 0, 0, 0, 32'h0, 0, 1);
        chk("r5.cur_lit", cur, 32'h28);
        chk("r5.unf_lit", {31'd0, ras_unf}, 32'd1);
        free("unf.clear");

        // Stall ignores jmp/call/ret; reset mid-run discards the stack
        cyc("c1", 0, 0, 1, 0, 32'h400, 1, 0);
        cyc("c2", 0, 0, 1, 0, 32'h800, 1, 0);
        cyc("stall", 0, 1, 1, 0, 32'h3000, 1, 0);
        chk("stall.cur_lit", cur, 32'h800);
        cyc("stallret", 0, 1, 0, 0, 32'h0, 0, 1);
        chk("stall.cnt_lit", {29'd0, ras_cnt}, 32'd2);
        cyc("midrst", 1, 0, 1, 0, 32'h5000, 1, 0);
        chk("midrst.cnt_lit", {29'd0, ras_cnt}, 32'd0);
        cyc("callnojmp", 0, 0, 0, 0, 32'h7000, 1, 0);

`ifdef PC_MISALIGN_EN
        cyc("misal", 0, 0, 1, 0, 32'h1002, 0, 0);
        chk("misal.cur_lit", cur, 32'h1000);
        chk("misal.mis_lit", {31'd0, mis}, 32'd1);
        free("misal.clear");
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, s, j, rl, c, rt;
            logic [31:0] n;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 2) == 0);
            rl = $urandom_range(0, 1) == 1;
            c  = ($urandom_range(0, 1) == 1);
            rt = ($urandom_range(0, 4) == 0);
            n  = $urandom();
            if ($urandom_range(0, 3) != 0) n[1:0] = 2'b00;
            cyc("rand", r, s, j, rl, n, c, rt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
